dot_update_queue: RTL
=====================

// Module: dot_update_queue
// PURPOSE
//   Buffers processor MMIO dot-location writes (addr 100..999) in a FIFO.
//   Drains them to the VGA dot table only while the display is blanked, so a
//   frame never shows half-updated dots.
//   Sits between the CPU data-memory port and the VGAController dot-update
//   inputs. Replaces the direct combinational dotWren/dotID/dotLoc decode.
// PARAMETERS
//   DEPTH     16   FIFO entries; power of 2, >= 2
//   X_BASE    100  first X-location address; dot id = addr - X_BASE
//   Y_BASE    550  first Y-location address; dot id = addr - Y_BASE
//   ADDR_TOP  999  last mapped address, inclusive
//   STAT_ADDR 98   read-only status word address
//   ID_W      9    dot id width (450 dots)
//   LOC_W     10   location width; the low LOC_W bits of the write data are kept
// PORTS
//   clock        in   1      CPU clock; all state updates on its rising edge
//   reset        in   1      synchronous, active-low: 0 = reset on next edge
//   mem_addr     in   32     CPU data address
//   mem_data     in   32     CPU store data
//   mem_wren     in   1      CPU store strobe
//   vga_blank    in   1      1 = outside the visible area (hblank or vblank);
//                            same clock domain
//   dot_wren     out  1      one-cycle write strobe to the dot table
//   dot_is_y     out  1      1 = Y coordinate, 0 = X coordinate
//   dot_id       out  ID_W   dot index
//   dot_loc      out  LOC_W  coordinate value
//   stat_hit     out  1      comb: mem_addr == STAT_ADDR
//   stat_data    out  32     comb: {overflow, full, empty, 24'b0, count[4:0]};
//                            count is zero-extended
// BEHAVIOUR
//   Decode (comb)
//     push_req = mem_wren && X_BASE <= mem_addr <= ADDR_TOP.
//     is_y = mem_addr >= Y_BASE.
//     id = mem_addr - (is_y ? Y_BASE : X_BASE), truncated to ID_W.
//     Entry = {is_y, id, mem_data[LOC_W-1:0]}.
//     Writes outside the mapped range are ignored.
//   Push
//     push_req && !full: write the entry at wr_ptr; wr_ptr+1; count+1.
//   Overflow
//     push_req && full && !pop: entry is dropped and the sticky overflow bit
//     is set. Overflow clears only on reset.
//   Pop
//     pop = vga_blank && !empty. Entry at rd_ptr goes into the output
//     registers; rd_ptr+1; count-1.
//   Outputs
//     dot_wren = registered pop: high exactly 1 cycle per entry.
//     dot_is_y, dot_id and dot_loc hold the last popped entry.
//   Simultaneous push and pop
//     Both occur; count is unchanged.
//     When full, the slot freed by the pop accepts the push; no overflow.
//   Latency
//     Write in cycle N with the queue empty and vga_blank high: dot_wren is
//     high in cycle N+2. There is no bypass path.
//   Ordering
//     Strict FIFO. Back-to-back writes to the same id are all delivered;
//     the last one wins.
//   Pointers
//     Wrap modulo DEPTH. count ranges 0..DEPTH.
//     full = (count == DEPTH); empty = (count == 0).
//   Blank deassert
//     Draining stops on the next edge. An entry already in the output
//     registers still completes its strobe.
//   Reset (reset == 0 at an edge)
//     Pointers, count and overflow return to 0; the queue is emptied.
//     dot_wren, dot_is_y, dot_id and dot_loc all become 0.
//     Entries queued before reset are lost and never emitted.
//     Reset overrides a push or pop in the same cycle.
// TESTING
//   1. Store 320 to addr 105 with vga_blank=0 for 5 cycles, then blank=1
//      -> 1 strobe: is_y=0, id=5, loc=320. No strobe while blank=0.
//   2. Store 200 to addr 560 with blank=1 held -> dot_wren 2 cycles later:
//      is_y=1, id=10, loc=200.
//   3. 17 stores (addr 100..116) with blank=0 -> count=16, full=1,
//      overflow=1. Raise blank -> exactly 16 strobes, ids 0..15 in order.
//   4. Queue full, blank=1, store in the same cycle as a pop -> no overflow,
//      count stays 16, the new entry is emitted last.
//   5. Stores to addrs 99 and 1000, plus a load of addr 98 -> no push.
//      stat_hit=1; stat_data shows empty=1, count=0.
//   6. Queue 4 entries, pull reset low for 1 cycle, then blank=1
//      -> no strobes; count=0 and overflow=0.

Source files
------------

// File: rtl/dot_update_queue.sv
// dot_update_queue: buffers CPU MMIO dot-location stores in a FIFO and
// drains them to the VGA dot table only while the display is blanked, so a
// visible frame never shows a half-updated set of dots.
module dot_update_queue #(
    parameter int DEPTH     = 16,
    parameter int X_BASE    = 100,
    parameter int Y_BASE    = 550,
    parameter int ADDR_TOP  = 999,
    parameter int STAT_ADDR = 98,
    parameter int ID_W      = 9,
    parameter int LOC_W     = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    input  logic             mem_wren,
    input  logic             vga_blank,
    output logic             dot_wren,
    output logic             dot_is_y,
    output logic [ID_W-1:0]  dot_id,
    output logic [LOC_W-1:0] dot_loc,
    output logic             stat_hit,
    output logic [31:0]      stat_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ID_W + LOC_W;

    // Queue storage; each entry is {is_y, id, loc}
    logic [ENT_W-1:0] fifo_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;

    logic             dot_wren_reg;
    logic             dot_is_y_reg;
    logic [ID_W-1:0]  dot_id_reg;
    logic [LOC_W-1:0] dot_loc_reg;

    logic             in_range;
    logic             push_req;
    logic             is_y;
    logic [ID_W-1:0]  push_id;
    logic [ENT_W-1:0] push_entry;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;
    logic [4:0]       count_5;

    // Only the low LOC_W bits of the store data carry a coordinate
    logic             unused_data_bits;
    assign unused_data_bits = ^mem_data[31:LOC_W];

    // Address decode: X block first, Y block starts at Y_BASE
    assign in_range   = (mem_addr >= 32'(X_BASE)) && (mem_addr <= 32'(ADDR_TOP));
    assign push_req   = mem_wren && in_range;
    assign is_y       = (mem_addr >= 32'(Y_BASE));
    assign push_id    = ID_W'(mem_addr - (is_y ? 32'(Y_BASE) : 32'(X_BASE)));
    assign push_entry = {is_y, push_id, mem_data[LOC_W-1:0]};

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = vga_blank && !empty;
    // When full, a same-cycle pop frees the slot the push lands in
    assign push_ok = push_req && (!full || pop);

    // Store accepted entries; reset blocks the write along with the pointers
    always_ff @(posedge clock) begin
        if (reset && push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Registered read into the dot-table outputs; strobe lasts one cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            dot_wren_reg <= 1'b0;
            dot_is_y_reg <= 1'b0;
            dot_id_reg   <= '0;
            dot_loc_reg  <= '0;
        end else begin
            dot_wren_reg <= pop;
            if (pop) begin
                {dot_is_y_reg, dot_id_reg, dot_loc_reg} <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    assign dot_wren = dot_wren_reg;
    assign dot_is_y = dot_is_y_reg;
    assign dot_id   = dot_id_reg;
    assign dot_loc  = dot_loc_reg;

    // Status word is a combinational read of the live queue state
    assign count_5   = 5'(count_reg);
    assign stat_hit  = (mem_addr == 32'(STAT_ADDR));
    assign stat_data = {overflow_reg, full, empty, 24'b0, count_5};

endmodule
